// File: rtl/sig_stim.sv
// rtl/sig_stim.sv - signature-analyzer probe stimulus generator (start/clock/data/stop bursts).
// Optional macro SIG_STIM_EXPECT_EN adds a 16-bit expected-signature model on exp_sig.
module sig_stim #(
    parameter int MAX_BITS = 32,
    parameter int DIV_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                abort,
    input  logic [MAX_BITS-1:0] pattern,
    input  logic [5:0]          length,
    input  logic [DIV_W-1:0]    div,
    output logic                sa_clk,
    output logic                sa_start,
    output logic                sa_stop,
    output logic                sa_data,
    output logic                busy,
    output logic                done,
    output logic [15:0]         exp_sig
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        SHIFT = 3'd2,
        TRAIL = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [5:0] MAX_LEN = 6'(MAX_BITS);

    state_t              state;
    logic [DIV_W-1:0]    div_r;
    logic [DIV_W-1:0]    div_cnt;
    logic [5:0]          len_r;
    logic [5:0]          bit_cnt;
    logic [MAX_BITS-1:0] pat_r;

    logic [5:0] len_clamped;
    logic       phase_end;
    logic       start_burst;

    assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
    assign phase_end   = (div_cnt == div_r);
    assign start_burst = (state == IDLE) && go && !abort;

    // Period = low phase then high phase, each div_r+1 clocks. All data
    // outputs update together with the falling edge of sa_clk, so they are
    // settled long before the analyzer samples on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            div_r    <= '0;
            div_cnt  <= '0;
            len_r    <= '0;
            bit_cnt  <= '0;
            pat_r    <= '0;
            sa_clk   <= 1'b0;
            sa_start <= 1'b0;
            sa_stop  <= 1'b0;
            sa_data  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (abort && (state != IDLE)) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sa_clk   <= 1'b0;
            sa_start <= 1'b0;
            sa_stop  <= 1'b0;
            sa_data  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sa_clk   <= 1'b0;
                    sa_start <= 1'b0;
                    sa_stop  <= 1'b0;
                    sa_data  <= 1'b0;
                    done     <= 1'b0;
                    busy     <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    if (start_burst) begin
                        state    <= LEAD;
                        div_r    <= div;
                        len_r    <= len_clamped;
                        pat_r    <= pattern;
                        busy     <= 1'b1;
                        sa_start <= 1'b1;
                    end
                end

                LEAD, SHIFT, TRAIL: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!sa_clk) begin
                            sa_clk <= 1'b1;
                        end else begin
                            sa_clk <= 1'b0;
                            case (state)
                                LEAD: begin
                                    sa_start <= 1'b0;
                                    if (len_r == 6'd0) begin
                                        state   <= TRAIL;
                                        sa_stop <= 1'b1;
                                        sa_data <= 1'b0;
                                    end else begin
                                        state   <= SHIFT;
                                        sa_data <= pat_r[0];
                                        pat_r   <= pat_r >> 1;
                                        bit_cnt <= 6'd1;
                                    end
                                end
                                SHIFT: begin
                                    if (bit_cnt == len_r) begin
                                        state   <= TRAIL;
                                        sa_stop <= 1'b1;
                                        sa_data <= 1'b0;
                                    end else begin
                                        sa_data <= pat_r[0];
                                        pat_r   <= pat_r >> 1;
                                        bit_cnt <= bit_cnt + 6'd1;
                                    end
                                end
                                default: begin
                                    state   <= FIN;
                                    sa_stop <= 1'b0;
                                    sa_data <= 1'b0;
                                    busy    <= 1'b0;
                                    done    <= 1'b1;
                                end
                            endcase
                        end
                    end
                end

                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIG_STIM_EXPECT_EN
    logic [15:0] sig;
    logic        sig_tick;

    // One update per analyzer sampling edge inside the data field.
    assign sig_tick = (state == SHIFT) && phase_end && !sa_clk && !abort;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig <= 16'h0000;
        end else if (start_burst) begin
            sig <= 16'h0000;
        end else if (sig_tick) begin
            sig <= {sig[14:0], sa_data ^ sig[6] ^ sig[8] ^ sig[11] ^ sig[15]};
        end
    end

    assign exp_sig = sig;
`else
    assign exp_sig = 16'h0000;
`endif

endmodule
